// File: rtl/phase_detector_multi.sv
// Multi-channel start/stop phase counter: per channel, counts clk_fast ticks from a start
// rise to the next stop rise, with timeout saturation and a running block average.
module phase_detector_multi #(
    parameter int NCH      = 4,
    parameter int WIDTH    = 8,
    parameter int AVG_LOG2 = 3
) (
    input  logic                 clk_fast,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 clr_avg,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       stop,
    output logic [NCH*WIDTH-1:0] phase_diff,
    output logic [NCH-1:0]       diff_valid,
    output logic [NCH-1:0]       diff_ovf,
    output logic [NCH*WIDTH-1:0] phase_avg,
    output logic [NCH-1:0]       avg_valid
);

    localparam int AW = WIDTH + AVG_LOG2;
    localparam int SW = AVG_LOG2 + 1;
    localparam logic [WIDTH-1:0] MAX   = '1;
    localparam logic [SW-1:0]    SLAST = SW'((1 << AVG_LOG2) - 1);

    typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

    logic [NCH-1:0] start_prev_q;
    logic [NCH-1:0] stop_prev_q;
    logic           primed_q;
    logic [NCH-1:0] start_rise;
    logic [NCH-1:0] stop_rise;

    // primed_q masks the first sample after reset so a level already high is not an edge.
    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            start_prev_q <= '0;
            stop_prev_q  <= '0;
            primed_q     <= 1'b0;
        end else begin
            start_prev_q <= start;
            stop_prev_q  <= stop;
            primed_q     <= 1'b1;
        end
    end

    assign start_rise = start & ~start_prev_q & {NCH{primed_q}};
    assign stop_rise  = stop  & ~stop_prev_q  & {NCH{primed_q}};

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            state_t           state_q, state_d;
            logic [WIDTH-1:0] cnt_q, cnt_d;
            logic [WIDTH-1:0] diff_q, diff_d;
            logic             ovf_q, ovf_d;
            logic             dvalid_q;
            logic [AW-1:0]    acc_q, acc_d;
            logic [SW-1:0]    scount_q, scount_d;
            logic [WIDTH-1:0] avg_q, avg_d;
            logic             avalid_q, avalid_d;
            logic             done;
            logic             ovf;
            logic [WIDTH-1:0] result;
            logic [AW-1:0]    sum;

            always_ff @(posedge clk_fast or negedge rstn) begin
                if (!rstn) begin
                    state_q  <= IDLE;
                    cnt_q    <= '0;
                    diff_q   <= '0;
                    ovf_q    <= 1'b0;
                    dvalid_q <= 1'b0;
                    acc_q    <= '0;
                    scount_q <= '0;
                    avg_q    <= '0;
                    avalid_q <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    cnt_q    <= cnt_d;
                    diff_q   <= diff_d;
                    ovf_q    <= ovf_d;
                    dvalid_q <= done;
                    acc_q    <= acc_d;
                    scount_q <= scount_d;
                    avg_q    <= avg_d;
                    avalid_q <= avalid_d;
                end
            end

            // cnt_q holds the ticks elapsed since the start edge as seen at the current edge.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (start_rise[gi] && !stop_rise[gi]) begin
                                state_d = COUNT;
                                cnt_d   = WIDTH'(1);
                            end
                        end
                        COUNT: begin
                            if (stop_rise[gi]) begin
                                state_d = IDLE;
                            end else if (start_rise[gi]) begin
                                cnt_d = WIDTH'(1);
                            end else if (cnt_q == MAX) begin
                                state_d = IDLE;
                            end else begin
                                cnt_d = cnt_q + WIDTH'(1);
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end

            always_comb begin
                done   = 1'b0;
                ovf    = 1'b0;
                result = cnt_q;
                if (enable) begin
                    case (state_q)
                        IDLE: begin
                            if (start_rise[gi] && stop_rise[gi]) begin
                                done   = 1'b1;
                                result = '0;
                            end
                        end
                        COUNT: begin
                            if (stop_rise[gi]) begin
                                done = 1'b1;
                            end else if (!start_rise[gi] && cnt_q == MAX) begin
                                done = 1'b1;
                                ovf  = 1'b1;
                            end
                        end
                        default: done = 1'b0;
                    endcase
                end

                diff_d = done ? result : diff_q;
                ovf_d  = done ? ovf : ovf_q;

                // A clear wins over a result arriving in the same cycle.
                sum      = acc_q + AW'(result);
                acc_d    = acc_q;
                scount_d = scount_q;
                avg_d    = avg_q;
                avalid_d = 1'b0;
                if (clr_avg) begin
                    acc_d    = '0;
                    scount_d = '0;
                end else if (done) begin
                    if (scount_q == SLAST) begin
                        avg_d    = WIDTH'(sum >> AVG_LOG2);
                        avalid_d = 1'b1;
                        acc_d    = '0;
                        scount_d = '0;
                    end else begin
                        acc_d    = sum;
                        scount_d = scount_q + SW'(1);
                    end
                end
            end

            assign phase_diff[gi*WIDTH +: WIDTH] = diff_q;
            assign diff_valid[gi]                = dvalid_q;
            assign diff_ovf[gi]                  = ovf_q;
            assign phase_avg[gi*WIDTH +: WIDTH]  = avg_q;
            assign avg_valid[gi]                 = avalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_phase_detector_multi.sv
// Self-checking bench for phase_detector_multi: cycle-number based reference model,
// per-cycle compare process, directed scenarios and a randomized soak.
module tb_phase_detector_multi;
    localparam int NCH = 2;
    localparam int WIDTH = 8;
    localparam int AVG_LOG2 = 2;
    localparam int MAX = 255;
    localparam int BLK = 4;

    logic             clk_fast = 1'b0;
    logic             rstn = 1'b0;
    logic             enable = 1'b0;
    logic             clr_avg = 1'b0;
    logic [NCH-1:0]   start = '0;
    logic [NCH-1:0]   stop = '0;
    logic [NCH*WIDTH-1:0] phase_diff;
    logic [NCH-1:0]   diff_valid;
    logic [NCH-1:0]   diff_ovf;
    logic [NCH*WIDTH-1:0] phase_avg;
    logic [NCH-1:0]   avg_valid;

    phase_detector_multi #(.NCH(NCH), .WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2)) dut (
        .clk_fast(clk_fast), .rstn(rstn), .enable(enable), .clr_avg(clr_avg),
        .start(start), .stop(stop),
        .phase_diff(phase_diff), .diff_valid(diff_valid), .diff_ovf(diff_ovf),
        .phase_avg(phase_avg), .avg_valid(avg_valid)
    );

    always #5 clk_fast = ~clk_fast;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remembers the cycle number of the arming start edge per channel
    // and the running sum/count of the current averaging block.
    int  cyc = 0;
    bit  m_have = 1'b0;
    logic [NCH-1:0] m_prev_s = '0;
    logic [NCH-1:0] m_prev_p = '0;
    bit  m_armed [NCH];
    int  m_n     [NCH];
    int  m_sum   [NCH];
    int  m_cnt   [NCH];
    int  exp_diff[NCH];
    bit  exp_ovf [NCH];
    bit  exp_dv  [NCH];
    int  exp_avg [NCH];
    bit  exp_av  [NCH];

    always @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            m_have = 1'b0;
            m_prev_s = '0;
            m_prev_p = '0;
            for (int c = 0; c < NCH; c++) begin
                m_armed[c] = 0; m_n[c] = 0; m_sum[c] = 0; m_cnt[c] = 0;
                exp_diff[c] = 0; exp_ovf[c] = 0; exp_dv[c] = 0; exp_avg[c] = 0; exp_av[c] = 0;
            end
        end else begin
            cyc++;
            for (int c = 0; c < NCH; c++) begin
                bit rs, rp, got, o;
                int r;
                rs = m_have && start[c] && !m_prev_s[c];
                rp = m_have && stop[c] && !m_prev_p[c];
                got = 0; o = 0; r = 0;
                exp_dv[c] = 0;
                exp_av[c] = 0;
                if (!enable) begin
                    m_armed[c] = 0;
                end else if (m_armed[c]) begin
                    if (rp) begin
                        got = 1; r = cyc - m_n[c]; m_armed[c] = 0;
                    end else if (rs) begin
                        m_n[c] = cyc;
                    end else if (cyc - m_n[c] >= MAX) begin
                        got = 1; r = MAX; o = 1; m_armed[c] = 0;
                    end
                end else if (rs && rp) begin
                    got = 1; r = 0;
                end else if (rs) begin
                    m_armed[c] = 1; m_n[c] = cyc;
                end
                if (got) begin
                    exp_diff[c] = r; exp_ovf[c] = o; exp_dv[c] = 1;
                end
                if (clr_avg) begin
                    m_sum[c] = 0; m_cnt[c] = 0;
                end else if (got) begin
                    m_sum[c] += r;
                    m_cnt[c]++;
                    if (m_cnt[c] == BLK) begin
                        exp_avg[c] = m_sum[c] / BLK; exp_av[c] = 1;
                        m_sum[c] = 0; m_cnt[c] = 0;
                    end
                end
            end
            m_prev_s = start;
            m_prev_p = stop;
            m_have = 1'b1;
        end
    end

    always @(negedge clk_fast) begin
        if (cmp_en) begin
            for (int c = 0; c < NCH; c++) begin
                chk("phase_diff", 32'(phase_diff[c*WIDTH +: WIDTH]), 32'(exp_diff[c]));
                chk("diff_valid", 32'(diff_valid[c]), 32'(exp_dv[c]));
                chk("diff_ovf", 32'(diff_ovf[c]), 32'(exp_ovf[c]));
                chk("phase_avg", 32'(phase_avg[c*WIDTH +: WIDTH]), 32'(exp_avg[c]));
                chk("avg_valid", 32'(avg_valid[c]), 32'(exp_av[c]));
            end
        end
    end

    task automatic measure(input int ch, input int len, output logic [7:0] pd, output logic dv,
                           output logic [7:0] av_val, output logic av);
        start[ch] = 1'b1;
        repeat (len) @(negedge clk_fast);
        stop[ch] = 1'b1;
        @(negedge clk_fast);
        pd = phase_diff[ch*WIDTH +: WIDTH];
        dv = diff_valid[ch];
        av_val = phase_avg[ch*WIDTH +: WIDTH];
        av = avg_valid[ch];
        start[ch] = 1'b0;
        stop[ch] = 1'b0;
        @(negedge clk_fast);
    endtask

    task automatic timeout_run(input int ch);
        start[ch] = 1'b1;
        repeat (260) @(negedge clk_fast);
        start[ch] = 1'b0;
        @(negedge clk_fast);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pd, avv;
        logic dv, av;
        int n;
        int sp;
        int lens[4];

        // Start already high out of reset: no edge.
        start[0] = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk_fast);
        rstn = 1'b1;
        cmp_en = 1'b1;
        n = 0;
        repeat (20) begin @(negedge clk_fast); n += diff_valid[0]; end
        chk("no_edge_strobes", n, 0);
        chk("reset_phase_diff", 32'(phase_diff), 0);
        chk("reset_phase_avg", 32'(phase_avg), 0);
        start[0] = 1'b0;
        @(negedge clk_fast);

        measure(0, 25, pd, dv, avv, av);
        chk("basic_result", pd, 25);
        chk("basic_valid", dv, 1);
        chk("basic_ovf", diff_ovf[0], 0);
        chk("basic_pulse_once", diff_valid[0], 0);

        // Timeout on ch1, then a late stop must be ignored.
        start[1] = 1'b1;
        n = 0;
        repeat (300) begin @(negedge clk_fast); n += diff_valid[1]; end
        chk("timeout_strobes", n, 1);
        chk("timeout_value", phase_diff[15:8], 255);
        chk("timeout_ovf", diff_ovf[1], 1);
        stop[1] = 1'b1;
        n = 0;
        repeat (10) begin @(negedge clk_fast); n += diff_valid[1]; end
        chk("late_stop_strobes", n, 0);
        start[1] = 1'b0;
        stop[1] = 1'b0;
        @(negedge clk_fast);

        // Restart: start at 0, re-start at 20, stop at 50 -> 30.
        start[0] = 1'b1;
        repeat (10) @(negedge clk_fast);
        start[0] = 1'b0;
        repeat (10) @(negedge clk_fast);
        start[0] = 1'b1;
        n = 0;
        repeat (30) begin @(negedge clk_fast); n += diff_valid[0]; end
        chk("restart_no_strobe", n, 0);
        stop[0] = 1'b1;
        @(negedge clk_fast);
        chk("restart_result", phase_diff[7:0], 30);
        chk("restart_valid", diff_valid[0], 1);
        start[0] = 1'b0;
        stop[0] = 1'b0;
        @(negedge clk_fast);

        measure(0, 0, pd, dv, avv, av);
        chk("same_cycle_result", pd, 0);
        chk("same_cycle_valid", dv, 1);

        // Averaging blocks.
        clr_avg = 1'b1;
        @(negedge clk_fast);
        clr_avg = 1'b0;
        lens = '{10, 20, 31, 40};
        for (int k = 0; k < 4; k++) begin
            measure(0, lens[k], pd, dv, avv, av);
            chk("avg_block_result", pd, lens[k]);
            chk("avg_block_strobe", av, (k == 3) ? 1 : 0);
        end
        chk("avg_block_value", avv, 25);
        for (int k = 0; k < 4; k++) timeout_run(0);
        chk("avg_timeout_value", phase_avg[7:0], 255);

        // enable low mid-count discards the measurement.
        start[0] = 1'b1;
        repeat (10) @(negedge clk_fast);
        enable = 1'b0;
        repeat (5) @(negedge clk_fast);
        enable = 1'b1;
        n = 0;
        repeat (300) begin @(negedge clk_fast); n += diff_valid[0]; end
        chk("disable_no_strobe", n, 0);
        start[0] = 1'b0;
        @(negedge clk_fast);

        // Async reset mid-count clears outputs immediately.
        start[0] = 1'b1;
        repeat (10) @(negedge clk_fast);
        @(posedge clk_fast);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_phase_diff", 32'(phase_diff), 0);
        chk("async_rst_phase_avg", 32'(phase_avg), 0);
        chk("async_rst_ovf", 32'(diff_ovf), 0);
        chk("async_rst_valid", 32'(diff_valid), 0);
        @(negedge clk_fast);
        rstn = 1'b1;
        n = 0;
        repeat (10) begin @(negedge clk_fast); n += diff_valid[0]; end
        chk("post_rst_no_strobe", n, 0);
        start[0] = 1'b0;
        @(negedge clk_fast);

        // clr_avg after two results, then four results of 8.
        measure(0, 50, pd, dv, avv, av);
        measure(0, 60, pd, dv, avv, av);
        clr_avg = 1'b1;
        @(negedge clk_fast);
        clr_avg = 1'b0;
        for (int k = 0; k < 4; k++) measure(0, 8, pd, dv, avv, av);
        chk("clr_avg_strobe", av, 1);
        chk("clr_avg_value", avv, 8);

        // Randomized soak, second half with rare stops to provoke timeouts.
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk_fast);
            sp = (t < 2500) ? 15 : 400;
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 15) == 0) start[c] = ~start[c];
                if ($urandom_range(0, sp) == 0) stop[c] = ~stop[c];
            end
            enable = ($urandom_range(0, 99) != 0);
            clr_avg = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk_fast);
        enable = 1'b1;
        clr_avg = 1'b0;
        repeat (3) @(negedge clk_fast);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/phase_detector_multi.md
Name: phase_detector_multi

Overview:
- Multi-channel successor to the single-channel start/stop phase counter.
- Each of NCH channels measures the clk_fast ticks between a rising edge on its start input and the next rising edge on its stop input.
- Adds edge detection, a saturation/timeout flag, per-result valid strobes and a running block average per channel.
- Sits beside the trigger/echo logic on the ADC board; results go to the register readout.

Parameters:
- NCH, 4, number of independent channels.
- WIDTH, 8, bits per phase result; MAX = 2^WIDTH-1.
- AVG_LOG2, 3, average taken over 2^AVG_LOG2 consecutive results (0 = average equals latest result).

Ports:
- clk_fast  in  1  counting clock; all logic on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  high = channels operate; low = all channels forced to IDLE, no strobes.
- clr_avg  in  1  synchronous clear of all accumulators and sample counts.
- start  in  NCH  per-channel start signal, synchronous to clk_fast.
- stop  in  NCH  per-channel echo signal, synchronous to clk_fast.
- phase_diff  out  NCH*WIDTH  last result; channel i at bits [i*WIDTH +: WIDTH].
- diff_valid  out  NCH  1-cycle strobe when phase_diff[i] updates.
- diff_ovf  out  NCH  overflow flag for the last result of channel i, held with the result.
- phase_avg  out  NCH*WIDTH  last completed block average, same packing as phase_diff.
- avg_valid  out  NCH  1-cycle strobe when phase_avg[i] updates.

Behaviour:
- Reset (rstn low, async): all outputs 0; channel FSMs to IDLE; edge registers, counters, accumulators and sample counts to 0.
- Edge detect: registered previous value per input. Rise = input high while previous low. An input already high out of reset is not an edge.
- Per-channel FSM, IDLE/COUNT:
  - IDLE + start rise at cycle N -> COUNT with cnt cleared. Counting starts from the start edge, not the start level.
  - Stop rise while in IDLE (without start rise) -> ignored.
- Result definition: stop rise detected at cycle M while in COUNT -> result = M-N.
  - Registered: phase_diff and diff_valid update at cycle M+1.
  - diff_ovf = 0; FSM returns to IDLE.
- Same-cycle start and stop rise in IDLE -> result 0, diff_ovf = 0, valid next cycle, stays IDLE.
- Start rise while in COUNT (no stop rise) -> restart: cnt cleared, N = current cycle, no strobe.
- Start and stop rise together in COUNT -> complete the current measurement with the stop, then IDLE. The start is not re-armed.
- Timeout: if M-N would exceed MAX, abort on the cycle cnt reaches MAX. Outputs phase_diff = MAX, diff_ovf = 1, diff_valid strobe; FSM to IDLE. A later stop is ignored.
- enable low: FSMs forced to IDLE, in-flight measurement discarded (no strobe), accumulators hold. Edge registers keep sampling, so an input that stays high across re-enable produces no edge.
- Averaging, per channel, applied to every diff_valid result (overflowed results count as MAX):
  - acc (WIDTH+AVG_LOG2 bits, cannot overflow) += result; scount += 1.
  - When scount reaches 2^AVG_LOG2: phase_avg = (acc+result) >> AVG_LOG2 (truncating), avg_valid strobe in the same cycle as that diff_valid, then acc and scount cleared.
- clr_avg: acc and scount cleared next edge. phase_avg is held. A result strobing in the same cycle is discarded from the average.
- Channels are fully independent. Simultaneous completions on several channels all strobe in the same cycle.

Test Plan:
All scenarios use NCH=2, WIDTH=8, AVG_LOG2=2.
- Reset release, start held high on ch0 from time 0 -> no edge: no diff_valid; all outputs 0.
- ch0 start rise at cycle 10, stop rise at cycle 35 -> phase_diff[7:0]=25, diff_ovf[0]=0, diff_valid[0] pulse at cycle 36 only.
- ch1 start rise, no stop for 300 cycles -> phase_diff[15:8]=255, diff_ovf[1]=1, one strobe. A later stop rise produces no strobe.
- ch0 start at cycle 0, second start at cycle 20, stop at cycle 50 -> single result 30. Separately: same-cycle start+stop rise in IDLE -> result 0.
- ch0 results 10, 20, 31, 40 -> avg_valid[0] with the 4th diff_valid, phase_avg[7:0]=25. Next block of four results of 255 (timeouts) -> phase_avg=255.
- Mid-count: assert enable=0, then rstn=0 on a different run -> no strobe, outputs cleared asynchronously. clr_avg after 2 results, then 4 results of 8 -> phase_avg=8.
